sincos_arbiter: RTL and testbench
=================================

SINCOS_ARBITER -- requirements
Module: sincos_arbiter

Interface
REQ-001 The block SHALL provide parameter NREQ, default 4, number of requesters sharing one sincos core.
REQ-002 The block SHALL provide parameter TIMEOUT_CYCLES, default 64, watchdog limit in WAIT, used only when SINCOS_ARB_TIMEOUT_EN is defined.
REQ-003 The block SHALL have the port clk, input, 1 bit, single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have the port n_rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have the port req_valid, input, NREQ bits, per-requester request.
REQ-006 The block SHALL have the port req_opx, input, 32*NREQ bits, IEEE-754 single operand; requester i occupies bits [32i+31:32i].
REQ-007 The block SHALL have the port req_ready, output, NREQ bits, one-hot accept strobe.
REQ-008 The block SHALL have the port rsp_valid, output, NREQ bits, one-hot result valid.
REQ-009 The block SHALL have the port rsp_ready, input, NREQ bits, per-requester result accept.
REQ-010 The block SHALL have the port rsp_sine, output, 32 bits, shared sine result bus.
REQ-011 The block SHALL have the port rsp_cosine, output, 32 bits, shared cosine result bus.
REQ-012 The block SHALL have the port rsp_err, output, 1 bit, timeout flag qualifying rsp_valid.
REQ-013 The block SHALL have the port core_start, output, 1 bit, drives the sincos sine_start input.
REQ-014 The block SHALL have the port core_opx, output, 32 bits, drives the sincos opx input.
REQ-015 The block SHALL have the port core_done, input, 1 bit, from the sincos sine_done output.
REQ-016 The block SHALL have the ports core_sine and core_cosine, input, 32 bits each, from the sincos sine_result and cosine_result outputs.
REQ-017 The block SHALL have the port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have four states, IDLE, ISSUE, WAIT and RESP, with all outputs registered.
REQ-019 In IDLE with any req_valid high, the FSM SHALL grant round-robin, searching upward from index ptr with wrap at NREQ-1 to 0.
REQ-020 In that same cycle, the FSM SHALL pulse req_ready[g] for 1 cycle, latch req_opx[g] and g, set ptr=(g+1) mod NREQ, and go to ISSUE.
REQ-021 In ISSUE, the FSM SHALL assert core_start for exactly 1 cycle with core_opx equal to the latched operand, then go to WAIT.
REQ-022 core_opx SHALL be held stable from ISSUE through RESP.
REQ-023 In WAIT, the FSM SHALL sample core_done; on core_done=1 it SHALL capture core_sine and core_cosine and go to RESP.
REQ-024 core_done asserted outside WAIT SHALL be ignored.
REQ-025 In RESP, the block SHALL hold rsp_valid[g]=1 with results stable until rsp_ready[g]=1, then go to IDLE in the next cycle.
REQ-026 rsp_ready of any non-granted requester SHALL be ignored.
REQ-027 Latency SHALL be: grant at cycle N, core_start at N+1, core_done at D, rsp_valid rises at D+1.
REQ-028 The minimum issue interval between back-to-back grants SHALL be 1 idle cycle after the RESP handshake.
REQ-029 req_valid dropped before grant SHALL cancel the request, with no side effects.
REQ-030 req_valid changes while busy SHALL be ignored until IDLE.
REQ-031 With a single active requester, that requester SHALL be granted on every IDLE visit.
REQ-032 The block SHALL perform no arithmetic on operands or results; it passes them through bit-exact.

Reset
REQ-033 On n_rst=0, asynchronously: state=IDLE, ptr=0, and all outputs (req_ready, rsp_valid, rsp_sine, rsp_cosine, rsp_err, core_start, core_opx, busy) SHALL be 0.
REQ-034 Reset mid-operation SHALL abort the transaction, produce no response, and deassert core_start immediately.
REQ-035 The first grant after reset release SHALL search from index 0.

Configuration
REQ-036 With macro SINCOS_ARB_TIMEOUT_EN defined, a counter cleared on WAIT entry SHALL count WAIT cycles.
REQ-037 With SINCOS_ARB_TIMEOUT_EN defined, reaching TIMEOUT_CYCLES without core_done SHALL force RESP with rsp_sine=rsp_cosine=32'h7FC00000 and rsp_err=1.
REQ-038 With SINCOS_ARB_TIMEOUT_EN defined, core_done in the same cycle as the timeout SHALL take precedence, giving the normal result with rsp_err=0.
REQ-039 Without SINCOS_ARB_TIMEOUT_EN, WAIT SHALL be held indefinitely, no counter SHALL exist, and rsp_err SHALL be tied to 0.

Verification
REQ-040 Single request, req1 opx=32'h3F490FD8, model returns 32'h3F3504F3/32'h3F3504F3 after 5 cycles -> one core_start, rsp_valid[1] with 32'h3F3504F3 on both buses.
REQ-041 All four req_valid high after reset -> grant order 0,1,2,3, one core_start per grant, results routed to matching rsp_valid bit.
REQ-042 req0 and req2 held continuously -> grants alternate 0,2,0,2, neither starved.
REQ-043 rsp_ready[g] held low 5 cycles in RESP -> rsp_valid and results stable throughout, no new grant until handshake.
REQ-044 n_rst pulsed low during WAIT -> all outputs 0 at once; a later core_done is ignored and the next grant starts from index 0.
REQ-045 With SINCOS_ARB_TIMEOUT_EN and core_done never asserted -> after 64 WAIT cycles, rsp_err=1 with 32'h7FC00000 on both buses.

Source files
------------

// File: rtl/sincos_arbiter.sv
// Round-robin arbiter that shares one sincos core among NREQ requesters.
// Optional WAIT watchdog is compiled in when SINCOS_ARB_TIMEOUT_EN is defined.
module sincos_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [32*NREQ-1:0]   req_opx,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [31:0]          rsp_sine,
  output logic [31:0]          rsp_cosine,
  output logic                 rsp_err,
  output logic                 core_start,
  output logic [31:0]          core_opx,
  input  logic                 core_done,
  input  logic [31:0]          core_sine,
  input  logic [31:0]          core_cosine,
  output logic                 busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW   = IDXW + 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  if (NREQ < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sincos_arbiter: NREQ and TIMEOUT_CYCLES must be at least 1");
  end

  state_t            state_q;
  logic [IDXW-1:0]   ptr_q;
  logic [IDXW-1:0]   gnt_q;
  logic [NREQ-1:0]   req_ready_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [31:0]       rsp_sine_q;
  logic [31:0]       rsp_cosine_q;
  logic              core_start_q;
  logic [31:0]       core_opx_q;
  logic              busy_q;

  logic [31:0]       opx_arr [NREQ];
  logic              grant_found_d;
  logic [IDXW-1:0]   grant_idx_d;
  logic [IDXW-1:0]   ptr_d;
  logic [CW-1:0]     cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_opx
    assign opx_arr[gi] = req_opx[32*gi +: 32];
  end

  // First valid requester at or after ptr_q, wrapping from NREQ-1 back to 0.
  always_comb begin
    grant_found_d = 1'b0;
    grant_idx_d   = '0;
    cand          = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + CW'(k);
      if (cand >= CW'(NREQ)) begin
        cand = cand - CW'(NREQ);
      end
      if (!grant_found_d && req_valid[cand[IDXW-1:0]]) begin
        grant_found_d = 1'b1;
        grant_idx_d   = cand[IDXW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = grant_idx_d + IDXW'(1);
    if (grant_idx_d == IDXW'(NREQ - 1)) begin
      ptr_d = '0;
    end
  end

`ifdef SINCOS_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic [CNTW-1:0] cnt_q;
  logic            rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_sine_q   <= '0;
      rsp_cosine_q <= '0;
      core_start_q <= 1'b0;
      core_opx_q   <= '0;
      busy_q       <= 1'b0;
`ifdef SINCOS_ARB_TIMEOUT_EN
      cnt_q        <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found_d) begin
            gnt_q       <= grant_idx_d;
            ptr_q       <= ptr_d;
            req_ready_q <= ONE << grant_idx_d;
            core_opx_q  <= opx_arr[grant_idx_d];
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          req_ready_q  <= '0;
          core_start_q <= 1'b1;
`ifdef SINCOS_ARB_TIMEOUT_EN
          cnt_q        <= '0;
`endif
          state_q      <= WAIT;
        end
        WAIT: begin
          core_start_q <= 1'b0;
          if (core_done) begin
            rsp_sine_q   <= core_sine;
            rsp_cosine_q <= core_cosine;
            rsp_valid_q  <= ONE << gnt_q;
            state_q      <= RESP;
`ifdef SINCOS_ARB_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // Core never answered: return a quiet NaN flagged as an error.
            rsp_sine_q   <= QNAN;
            rsp_cosine_q <= QNAN;
            rsp_err_q    <= 1'b1;
            rsp_valid_q  <= ONE << gnt_q;
            state_q      <= RESP;
          end else begin
            cnt_q        <= cnt_q + CNTW'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready[gnt_q]) begin
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
`ifdef SINCOS_ARB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sine   = rsp_sine_q;
  assign rsp_cosine = rsp_cosine_q;
  assign core_start = core_start_q;
  assign core_opx   = core_opx_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sincos_arbiter.sv
// Scoreboard bench for sincos_arbiter: stimulus queues expected grants/responses,
// monitors pop and compare; a behavioural sincos core answers core_start.
module tb_sincos_arbiter;
  localparam int NREQ = 4;
  localparam int TO   = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

  logic                clk = 1'b0;
  logic                n_rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_opx;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         rsp_sine;
  logic [31:0]         rsp_cosine;
  logic                rsp_err;
  logic                core_start;
  logic [31:0]         core_opx;
  logic                core_done;
  logic [31:0]         core_sine;
  logic [31:0]         core_cosine;
  logic                busy;

  always #5 clk = ~clk;

  sincos_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .n_rst(n_rst),
    .req_valid(req_valid), .req_opx(req_opx), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sine(rsp_sine), .rsp_cosine(rsp_cosine), .rsp_err(rsp_err),
    .core_start(core_start), .core_opx(core_opx), .core_done(core_done),
    .core_sine(core_sine), .core_cosine(core_cosine), .busy(busy)
  );

  typedef struct { int idx; logic [31:0] s; logic [31:0] c; logic err; } rsp_t;
  typedef struct { logic [31:0] s; logic [31:0] c; int lat; } core_t;

  int          exp_gnt_q[$];
  logic [31:0] exp_opx_q[$];
  core_t       core_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] opx_tbl [NREQ];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int grants_seen = 0, starts_seen = 0, rsps_seen = 0;
  int last_grant_cyc = 0, start_cyc = 0, done_cyc = 0, hs_cyc = 0;
  int g_pop;
  rsp_t er;
  core_t cur;
  logic prev_start = 1'b0;
  logic prev_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Grant monitor
  always @(negedge clk) begin
    if (n_rst && req_ready !== '0) begin
      if (exp_gnt_q.size() == 0) begin
        chk("grant_unexpected", 32'(req_ready), 32'h0);
      end else begin
        g_pop = exp_gnt_q.pop_front();
        chk("grant_onehot", 32'(req_ready), 32'(1) << g_pop);
      end
      grants_seen++;
      last_grant_cyc = cyc;
    end
  end

  // core_start must be a single-cycle pulse
  always @(negedge clk) begin
    if (prev_start) chk("start_width", 32'(core_start), 32'h0);
    prev_start = core_start;
  end

  // Behavioural sincos core
  initial begin
    core_done = 1'b0;
    core_sine = JUNK;
    core_cosine = JUNK;
    forever begin
      @(negedge clk);
      if (n_rst && core_start) begin
        starts_seen++;
        start_cyc = cyc;
        chk("start_latency", cyc, last_grant_cyc + 1);
        if (exp_opx_q.size() == 0 || core_q.size() == 0) begin
          chk("start_unexpected", 32'(core_start), 32'h0);
        end else begin
          chk("core_opx", core_opx, exp_opx_q.pop_front());
          cur = core_q.pop_front();
          if (cur.lat > 0) begin
            repeat (cur.lat) @(posedge clk);
            #1;
            core_done = 1'b1;
            core_sine = cur.s;
            core_cosine = cur.c;
            done_cyc = cyc;
            @(posedge clk);
            #1;
            core_done = 1'b0;
            core_sine = JUNK;
            core_cosine = JUNK;
          end
        end
      end
    end
  end

  // Response monitor: checks every valid cycle against the head, pops on handshake
  always @(negedge clk) begin
    if (rsp_valid !== '0) begin
      if (exp_rsp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
      end else begin
        er = exp_rsp_q[0];
        if (!prev_rsp) chk("rsp_latency", cyc, er.err ? start_cyc + TO : done_cyc + 1);
        chk("rsp_valid", 32'(rsp_valid), 32'(1) << er.idx);
        chk("rsp_sine", rsp_sine, er.s);
        chk("rsp_cosine", rsp_cosine, er.c);
        chk("rsp_err", 32'(rsp_err), 32'(er.err));
        if (rsp_ready[er.idx]) begin
          void'(exp_rsp_q.pop_front());
          rsps_seen++;
          hs_cyc = cyc;
          $display("rsp idx=%0d sine=%h cosine=%h err=%b cycle=%0d",
                   er.idx, rsp_sine, rsp_cosine, rsp_err, cyc);
        end
      end
    end
    prev_rsp = (rsp_valid !== '0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [31:0] s, input logic [31:0] c,
                      input int lat, input bit want_rsp);
    core_t ce;
    rsp_t re;
    exp_gnt_q.push_back(idx);
    exp_opx_q.push_back(opx_tbl[idx]);
    ce.s = s; ce.c = c; ce.lat = lat;
    core_q.push_back(ce);
    if (want_rsp) begin
      re.idx = idx;
      re.err = (lat < 0);
      re.s = (lat < 0) ? QNAN : s;
      re.c = (lat < 0) ? QNAN : c;
      exp_rsp_q.push_back(re);
    end
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (grants_seen < n && k < 300) begin tick(); k++; end
    chk(name, grants_seen, n);
  endtask

  task automatic wait_rsps(input int n, input string name);
    int k = 0;
    while (rsps_seen < n && k < 600) begin tick(); k++; end
    chk(name, rsps_seen, n);
  endtask

  task automatic wait_starts(input int n, input string name);
    int k = 0;
    while (starts_seen < n && k < 300) begin tick(); k++; end
    chk(name, starts_seen, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int g_tot = 0;
    int r_tot = 0;
    int s_tot = 0;
    int g_before;
    int k;

    opx_tbl[0] = 32'h3F80_0000;
    opx_tbl[1] = 32'h3F49_0FD8;
    opx_tbl[2] = 32'h4000_0000;
    opx_tbl[3] = 32'hBF00_0000;
    for (int i = 0; i < NREQ; i++) req_opx[32*i +: 32] = opx_tbl[i];
    req_valid = '0;
    rsp_ready = '1;
    n_rst = 1'b1;
    #1 n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_sine", rsp_sine, 0);
    chk("rst_rsp_cosine", rsp_cosine, 0);
    chk("rst_rsp_err", 32'(rsp_err), 0);
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_core_opx", core_opx, 0);
    chk("rst_busy", 32'(busy), 0);
    n_rst = 1'b1;

    // All four requesting: 0,1,2,3
    push(0, 32'h3F57_6AA4, 32'h3F0A_5140, 2, 1);
    push(1, 32'h3F35_04F3, 32'h3F35_04F4, 3, 1);
    push(2, 32'h3F68_C7B7, 32'hBED5_0B7C, 4, 1);
    push(3, 32'hBEF5_7E0E, 32'h3F60_A940, 5, 1);
    g_tot += 4; r_tot += 4;
    req_valid = 4'b1111;
    wait_grants(g_tot, "t41_grants");
    req_valid = '0;
    wait_rsps(r_tot, "t41_rsps");

    // req0 and req2 held: 0,2,0,2
    push(0, 32'h1111_0000, 32'h0000_1111, 2, 1);
    push(2, 32'h2222_0000, 32'h0000_2222, 3, 1);
    push(0, 32'h3333_0000, 32'h0000_3333, 1, 1);
    push(2, 32'h4444_0000, 32'h0000_4444, 2, 1);
    g_tot += 4; r_tot += 4;
    req_valid = 4'b0101;
    wait_grants(g_tot, "t42_grants");
    req_valid = '0;
    wait_rsps(r_tot, "t42_rsps");

    // Single request from req1, core answers after 5 cycles
    push(1, 32'h3F35_04F3, 32'h3F35_04F3, 5, 1);
    g_tot++; r_tot++;
    req_valid = 4'b0010;
    wait_grants(g_tot, "t40_grant");
    req_valid = '0;
    wait_rsps(r_tot, "t40_rsp");

    // Back-pressure: req2 held in RESP 5 cycles, others' rsp_ready high, req0 waiting
    push(2, 32'h5555_AAAA, 32'hAAAA_5555, 3, 1);
    push(0, 32'h6666_7777, 32'h7777_6666, 2, 1);
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    g_before = grants_seen;
    wait_grants(g_tot + 1, "t43_first_grant");
    req_valid = 4'b0001;
    k = 0;
    while (rsp_valid[2] !== 1'b1 && k < 100) begin tick(); k++; end
    chk("t43_rsp_seen", 32'(rsp_valid[2]), 1);
    repeat (5) tick();
    chk("t43_no_grant_in_resp", grants_seen, g_before + 1);
    rsp_ready = '1;
    g_tot += 2; r_tot += 2;
    wait_grants(g_tot, "t43_second_grant");
    req_valid = '0;
    chk("t43_reissue_gap", last_grant_cyc, hs_cyc + 2);
    wait_rsps(r_tot, "t43_rsps");

    // Lone requester granted on every IDLE visit
    push(3, 32'h0123_4567, 32'h89AB_CDEF, 1, 1);
    push(3, 32'h7654_3210, 32'hFEDC_BA98, 2, 1);
    push(3, 32'h8000_0000, 32'h0000_0001, 3, 1);
    g_tot += 3; r_tot += 3;
    req_valid = 4'b1000;
    wait_grants(g_tot, "t31_grants");
    req_valid = '0;
    wait_rsps(r_tot, "t31_rsps");

    // core_done on the last watchdog cycle still yields the real result
    push(0, 32'h3E80_0000, 32'h3F70_0000, TO - 1, 1);
    g_tot++; r_tot++;
    req_valid = 4'b0001;
    wait_grants(g_tot, "t38_grant");
    req_valid = '0;
    wait_rsps(r_tot, "t38_rsp");

`ifdef SINCOS_ARB_TIMEOUT_EN
    push(1, 32'h0, 32'h0, -1, 1);
    g_tot++; r_tot++;
    req_valid = 4'b0010;
    wait_grants(g_tot, "t45_grant");
    req_valid = '0;
    wait_rsps(r_tot, "t45_rsp");
`endif

    // Reset during WAIT: abort, ignore the late core_done, search restarts at 0
    push(2, 32'h3F68_0000, 32'h3ED7_0000, 10, 0);
    g_tot++;
    s_tot = starts_seen + 1;
    req_valid = 4'b0100;
    wait_grants(g_tot, "t44_grant");
    req_valid = '0;
    wait_starts(s_tot, "t44_start");
    chk("t44_busy_pre", 32'(busy), 1);
    chk("t44_opx_pre", core_opx, opx_tbl[2]);
    #2 n_rst = 1'b0;
    #1;
    chk("t44_req_ready", 32'(req_ready), 0);
    chk("t44_rsp_valid", 32'(rsp_valid), 0);
    chk("t44_rsp_sine", rsp_sine, 0);
    chk("t44_rsp_cosine", rsp_cosine, 0);
    chk("t44_rsp_err", 32'(rsp_err), 0);
    chk("t44_core_start", 32'(core_start), 0);
    chk("t44_core_opx", core_opx, 0);
    chk("t44_busy", 32'(busy), 0);
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (20) tick();
    chk("t44_idle_after_done", 32'(busy), 0);
    push(1, 32'h3DCC_CCCD, 32'h3F7E_C46D, 3, 1);
    g_tot++; r_tot++;
    req_valid = 4'b1010;
    wait_grants(g_tot, "t44_regrant");
    req_valid = '0;
    wait_rsps(r_tot, "t44_rsp");

    repeat (3) tick();
    chk("gnt_queue_empty", exp_gnt_q.size(), 0);
    chk("rsp_queue_empty", exp_rsp_q.size(), 0);
    chk("core_queue_empty", core_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
